multiport_regfile_sb: RTL and testbench

- Architectural integer register file with a busy scoreboard for the RISC-V core.
- Generalises the single reg_writer writeback path to NUM_WRITE writeback ports, NUM_READ read ports and NUM_RESERVE issue-time reservation ports.
- Sits between decode/issue (reads and reservations) and the writeback stage(s).
- Read ports return data plus a busy bit so issue can stall or forward.

---
 rtl/multiport_regfile_sb_pkg.sv | 26 ++
 rtl/multiport_regfile_sb_write_select.sv | 26 ++
 rtl/multiport_regfile_sb.sv | 117 +++++++++++
 tb/tb_multiport_regfile_sb.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multiport_regfile_sb_pkg.sv
// Shared types for the multi-port integer register file: writeback request,
// read request/response and architectural constants.
package multiport_regfile_sb_pkg;

  localparam int NUM_ARCH_REGS = 32;
  localparam int WORD_W        = 64;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [4:0]        reg_addr_t;

  typedef struct packed {
    reg_addr_t reg_dest_addr;
    logic      reg_write_enable;
    word_t     reg_write_data;
  } reg_writer;

  typedef struct packed {
    reg_addr_t addr;
  } rf_read_req;

  typedef struct packed {
    word_t data;
    logic  busy;
  } rf_read_resp;

endpackage

// File: rtl/multiport_regfile_sb_write_select.sv
// Picks the winning writeback for one register address; the highest-indexed
// enabled writer targeting that address wins, and x0 never matches.
module rf_write_select
  import multiport_regfile_sb_pkg::*;
#(
  parameter int NUM_WRITE = 2
) (
  input  reg_writer wb_i [NUM_WRITE],
  input  reg_addr_t addr_i,
  output logic      hit_o,
  output word_t     data_o
);

  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int k = 0; k < NUM_WRITE; k++) begin
      if (wb_i[k].reg_write_enable && (wb_i[k].reg_dest_addr != '0) &&
          (wb_i[k].reg_dest_addr == addr_i)) begin
        hit_o  = 1'b1;
        data_o = wb_i[k].reg_write_data;
      end
    end
  end

endmodule

// File: rtl/multiport_regfile_sb.sv
// Integer register file with busy scoreboard: NUM_WRITE writebacks, NUM_READ reads,
// NUM_RESERVE issue reservations. Define REGFILE_BYPASS_EN for write-to-read bypass.
module multiport_regfile_sb
  import multiport_regfile_sb_pkg::*;
#(
  parameter int NUM_WRITE   = 2,
  parameter int NUM_READ    = 4,
  parameter int NUM_RESERVE = 2,
  parameter int XLEN        = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  reg_writer       wb_i        [NUM_WRITE],
  input  logic [4:0]      rd_addr_i   [NUM_READ],
  output logic [XLEN-1:0] rd_data_o   [NUM_READ],
  output logic [NUM_READ-1:0] rd_busy_o,
  input  logic [NUM_RESERVE-1:0] rsv_valid_i,
  input  logic [4:0]      rsv_addr_i  [NUM_RESERVE],
  output logic [31:0]     wb_count_o
);

  word_t                    regs_q [NUM_ARCH_REGS];
  logic [NUM_ARCH_REGS-1:0] busy_q, busy_d, wb_mask, rsv_mask;
  logic [NUM_ARCH_REGS-1:0] upd_hit;
  word_t                    upd_data [NUM_ARCH_REGS];
  logic [NUM_WRITE-1:0]     wr_eff;
  logic [31:0]              wb_count_q, wb_count_d;
  logic [32:0]              cnt_sum;

  assign upd_hit[0]  = 1'b0;
  assign upd_data[0] = '0;

  for (genvar r = 1; r < NUM_ARCH_REGS; r++) begin : g_upd
    rf_write_select #(.NUM_WRITE(NUM_WRITE)) u_sel (
      .wb_i   (wb_i),
      .addr_i (reg_addr_t'(r)),
      .hit_o  (upd_hit[r]),
      .data_o (upd_data[r])
    );
  end

  always_comb begin
    wr_eff   = '0;
    wb_mask  = '0;
    rsv_mask = '0;
    for (int k = 0; k < NUM_WRITE; k++) begin
      if (wb_i[k].reg_write_enable && (wb_i[k].reg_dest_addr != '0)) begin
        wr_eff[k]                      = 1'b1;
        wb_mask[wb_i[k].reg_dest_addr] = 1'b1;
      end
    end
    for (int j = 0; j < NUM_RESERVE; j++) begin
      if (rsv_valid_i[j] && (rsv_addr_i[j] != '0)) rsv_mask[rsv_addr_i[j]] = 1'b1;
    end
    // Reservation applied after clear: a newer producer keeps the register busy.
    busy_d    = (busy_q & ~wb_mask) | rsv_mask;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    cnt_sum = {1'b0, wb_count_q};
    for (int k = 0; k < NUM_WRITE; k++) begin
      if (wr_eff[k]) cnt_sum = cnt_sum + 33'd1;
    end
    wb_count_d = cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_ARCH_REGS; r++) regs_q[r] <= '0;
      busy_q     <= '0;
      wb_count_q <= '0;
    end else begin
      for (int r = 0; r < NUM_ARCH_REGS; r++) begin
        if (upd_hit[r]) regs_q[r] <= upd_data[r];
      end
      busy_q     <= busy_d;
      wb_count_q <= wb_count_d;
    end
  end

  assign wb_count_o = wb_count_q;

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    rf_read_resp resp;
`ifdef REGFILE_BYPASS_EN
    logic  byp_hit;
    word_t byp_data;

    rf_write_select #(.NUM_WRITE(NUM_WRITE)) u_byp (
      .wb_i   (wb_i),
      .addr_i (rd_addr_i[i]),
      .hit_o  (byp_hit),
      .data_o (byp_data)
    );
`endif

    always_comb begin
      resp.data = regs_q[rd_addr_i[i]];
      resp.busy = busy_q[rd_addr_i[i]];
`ifdef REGFILE_BYPASS_EN
      if (byp_hit) begin
        resp.data = byp_data;
        resp.busy = rsv_mask[rd_addr_i[i]];
      end
`endif
      if (rd_addr_i[i] == '0) begin
        resp.data = '0;
        resp.busy = 1'b0;
      end
    end

    assign rd_data_o[i] = resp.data;
    assign rd_busy_o[i] = resp.busy;
  end

endmodule

// File: tb/tb_multiport_regfile_sb.sv
// Self-checking bench for multiport_regfile_sb: directed table, corner sequences,
// randomized traffic against a behavioural model. Honours REGFILE_BYPASS_EN.
module tb_multiport_regfile_sb;
  import multiport_regfile_sb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  reg_writer   wb [2];
  logic [4:0]  rd_addr [4];
  logic [63:0] rd_data [4];
  logic [3:0]  rd_busy;
  logic [1:0]  rsv_valid;
  logic [4:0]  rsv_addr [2];
  logic [31:0] wb_count;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_regs [32];
  logic        m_busy [32];
  longint      m_cnt;

  multiport_regfile_sb dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb_i        (wb),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data),
    .rd_busy_o   (rd_busy),
    .rsv_valid_i (rsv_valid),
    .rsv_addr_i  (rsv_addr),
    .wb_count_o  (wb_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  wa0; logic we0; logic [63:0] wd0;
    logic [4:0]  wa1; logic we1; logic [63:0] wd1;
    logic        rv0; logic [4:0] ra0;
    logic        rv1; logic [4:0] ra1;
    logic [4:0]  chk;
    logic [63:0] exp_data;
    logic        exp_busy;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs [9];

  function automatic vec_t mk(logic [4:0] wa0, logic we0, logic [63:0] wd0,
                              logic [4:0] wa1, logic we1, logic [63:0] wd1,
                              logic rv0, logic [4:0] ra0, logic rv1, logic [4:0] ra1,
                              logic [4:0] chk, logic [63:0] ed, logic eb, logic [31:0] ec);
    vec_t v;
    v.wa0 = wa0; v.we0 = we0; v.wd0 = wd0;
    v.wa1 = wa1; v.we1 = we1; v.wd1 = wd1;
    v.rv0 = rv0; v.ra0 = ra0; v.rv1 = rv1; v.ra1 = ra1;
    v.chk = chk; v.exp_data = ed; v.exp_busy = eb; v.exp_cnt = ec;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++) wb[k] = '0;
    for (int i = 0; i < 4; i++) rd_addr[i] = 5'd0;
    rsv_valid = 2'b00;
    rsv_addr[0] = 5'd0;
    rsv_addr[1] = 5'd0;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
    m_cnt = 0;
  endtask

  // Expected {busy, data} for a read of address a given the current inputs.
  function automatic logic [64:0] model_read(logic [4:0] a);
    logic [63:0] d;
    logic        b;
    if (a == 5'd0) return '0;
    d = m_regs[a];
    b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
    for (int k = 0; k < 2; k++) begin
      if (wb[k].reg_write_enable && wb[k].reg_dest_addr == a) begin
        d = wb[k].reg_write_data;
        b = 1'b0;
        for (int j = 0; j < 2; j++)
          if (rsv_valid[j] && rsv_addr[j] == a) b = 1'b1;
      end
    end
`endif
    return {b, d};
  endfunction

  task automatic model_clock();
    for (int k = 0; k < 2; k++) begin
      if (wb[k].reg_write_enable && wb[k].reg_dest_addr != 5'd0) begin
        m_regs[wb[k].reg_dest_addr] = wb[k].reg_write_data;
        m_busy[wb[k].reg_dest_addr] = 1'b0;
        m_cnt = m_cnt + 1;
      end
    end
    if (m_cnt > 64'hFFFF_FFFF) m_cnt = 64'hFFFF_FFFF;
    for (int j = 0; j < 2; j++)
      if (rsv_valid[j] && rsv_addr[j] != 5'd0) m_busy[rsv_addr[j]] = 1'b1;
  endtask

  task automatic compare_model();
    logic [64:0] e;
    for (int i = 0; i < 4; i++) begin
      e = model_read(rd_addr[i]);
      chk($sformatf("rd_data[%0d] x%0d", i, rd_addr[i]), rd_data[i], e[63:0]);
      chk($sformatf("rd_busy[%0d] x%0d", i, rd_addr[i]), {63'd0, rd_busy[i]}, {63'd0, e[64]});
    end
    chk("wb_count", {32'd0, wb_count}, m_cnt[63:0]);
  endtask

  // Inputs already driven after a negedge: check, clock, update model.
  task automatic step();
    #1;
    compare_model();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic set_wb(int k, logic [4:0] a, logic en, logic [63:0] d);
    wb[k].reg_dest_addr    = a;
    wb[k].reg_write_enable = en;
    wb[k].reg_write_data   = d;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();
    vecs[0] = mk(5'd7,  1, 64'h1111, 5'd7,  1, 64'h2222, 0, 5'd0,  0, 5'd0,  5'd7,  64'h2222, 0, 32'd2);
    vecs[1] = mk(5'd0,  1, 64'hFFFF, 5'd0,  0, 64'h0,    1, 5'd0,  0, 5'd0,  5'd0,  64'h0,    0, 32'd2);
    vecs[2] = mk(5'd0,  0, 64'h0,    5'd0,  0, 64'h0,    1, 5'd3,  0, 5'd0,  5'd3,  64'h0,    1, 32'd2);
    vecs[3] = mk(5'd3,  1, 64'h42,   5'd0,  0, 64'h0,    0, 5'd0,  1, 5'd3,  5'd3,  64'h42,   1, 32'd3);
    vecs[4] = mk(5'd0,  0, 64'h0,    5'd3,  1, 64'h55,   0, 5'd0,  0, 5'd0,  5'd3,  64'h55,   0, 32'd4);
    vecs[5] = mk(5'd9,  0, 64'hABCD, 5'd0,  0, 64'h0,    0, 5'd0,  0, 5'd0,  5'd9,  64'h0,    0, 32'd4);
    vecs[6] = mk(5'd0,  0, 64'h0,    5'd0,  0, 64'h0,    1, 5'd12, 1, 5'd12, 5'd12, 64'h0,    1, 32'd4);
    vecs[7] = mk(5'd12, 1, 64'h77,   5'd13, 1, 64'h88,   0, 5'd0,  0, 5'd0,  5'd12, 64'h77,   0, 32'd6);
    vecs[8] = mk(5'd13, 1, 64'h99,   5'd0,  1, 64'h5,    0, 5'd0,  0, 5'd0,  5'd13, 64'h99,   0, 32'd7);

    repeat (2) @(negedge clk);
    #1;
    chk("reset count", {32'd0, wb_count}, 64'd0);
    chk("reset busy", {60'd0, rd_busy}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 9; v++) begin
      idle();
      set_wb(0, vecs[v].wa0, vecs[v].we0, vecs[v].wd0);
      set_wb(1, vecs[v].wa1, vecs[v].we1, vecs[v].wd1);
      rsv_valid   = {vecs[v].rv1, vecs[v].rv0};
      rsv_addr[0] = vecs[v].ra0;
      rsv_addr[1] = vecs[v].ra1;
      step();
      idle();
      rd_addr[0] = vecs[v].chk;
      #1;
      chk($sformatf("vec%0d data", v), rd_data[0], vecs[v].exp_data);
      chk($sformatf("vec%0d busy", v), {63'd0, rd_busy[0]}, {63'd0, vecs[v].exp_busy});
      chk($sformatf("vec%0d count", v), {32'd0, wb_count}, {32'd0, vecs[v].exp_cnt});
      step();
    end

    // Same-cycle write and read of x9 (x9 still holds 0 here).
    idle();
    set_wb(0, 5'd9, 1'b1, 64'hABCD);
    rd_addr[1] = 5'd9;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass same-cycle", rd_data[1], 64'hABCD);
`else
    chk("no-bypass same-cycle", rd_data[1], 64'h0);
`endif
    step();
    idle();
    rd_addr[1] = 5'd9;
    #1;
    chk("x9 next cycle", rd_data[1], 64'hABCD);
    step();

    // Reset asserted in the same cycle as a write to x5.
    idle();
    rsv_valid = 2'b01;
    rsv_addr[0] = 5'd5;
    step();
    set_wb(0, 5'd5, 1'b1, 64'hDEAD);
    rd_addr[2] = 5'd5;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst x5 data", rd_data[2], 64'h0);
    chk("rst x5 busy", {63'd0, rd_busy[2]}, 64'd0);
    chk("rst count", {32'd0, wb_count}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    rd_addr[2] = 5'd5;
    #1;
    chk("post-rst x5 data", rd_data[2], 64'h0);
    step();

    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++)
        set_wb(k, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               {$urandom, $urandom});
      for (int i = 0; i < 4; i++) rd_addr[i] = 5'($urandom_range(0, 7));
      rsv_valid   = 2'($urandom_range(0, 3));
      rsv_addr[0] = 5'($urandom_range(0, 7));
      rsv_addr[1] = 5'($urandom_range(0, 7));
      step();
    end

    // Counter saturation.
    idle();
    force dut.wb_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.wb_count_q;
    m_cnt = 64'hFFFF_FFFE;
    chk("preload count", {32'd0, wb_count}, 64'hFFFF_FFFE);
    set_wb(0, 5'd20, 1'b1, 64'h1);
    set_wb(1, 5'd21, 1'b1, 64'h2);
    step();
    idle();
    #1;
    chk("saturate +2", {32'd0, wb_count}, 64'hFFFF_FFFF);
    set_wb(1, 5'd22, 1'b1, 64'h3);
    step();
    idle();
    #1;
    chk("saturate hold", {32'd0, wb_count}, 64'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
